// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the spi_master_n SPI master
package spi_pkg;

  // Frame sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_XFER  = 2'd2,
    ST_TRAIL = 2'd3
  } state_e;

  // SPI modes as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int MAX_BYTES_DEF = 4;

  // Smallest SCK period in clk cycles; smaller requests are raised to this
  localparam logic [7:0] CLK_DIV_MIN = 8'd4;

endpackage

// File: rtl/spi_half_tick.sv
// rtl/spi_half_tick.sv - reloadable down-counter emitting a tick every half SCK period
module spi_half_tick (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] half,
  output logic       tick
);

  logic [7:0] half_q, half_d;
  logic [7:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == 8'd0);

  // Load latches the period; while enabled the counter wraps on every tick
  always_comb begin
    half_d = half_q;
    cnt_d  = cnt_q;
    if (load) begin
      half_d = half;
      cnt_d  = half - 8'd1;
    end else if (en) begin
      cnt_d = (cnt_q == 8'd0) ? (half_q - 8'd1) : (cnt_q - 8'd1);
    end
  end

  // Counter state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_q <= 8'd2;
      cnt_q  <= 8'd0;
    end else begin
      half_q <= half_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_n.sv
// rtl/spi_master_n.sv - 1..MAX_BYTES byte SPI master, all modes, selectable bit order
module spi_master_n
  import spi_pkg::*;
#(
  parameter int MAX_BYTES = spi_pkg::MAX_BYTES_DEF,
  parameter int LW        = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             clk_div,
  input  logic                   cpol,
  input  logic                   cpha,
  input  logic                   lsb_first,
  input  logic [LW-1:0]          len,
  input  logic                   start,
  input  logic [8*MAX_BYTES-1:0] wrdata,
  output logic [8*MAX_BYTES-1:0] rddata,
  output logic                   done,
  output logic                   ready,
  output logic                   sck,
  output logic                   sdo,
  input  logic                   sdi,
  output logic                   ss
);

  localparam int W  = 8 * MAX_BYTES;
  localparam int NW = $clog2(W + 1);
  localparam int BW = (W > 1) ? $clog2(W) : 1;

  state_e        state_q, state_d;
  logic          cpol_q, cpol_d;
  logic          cpha_q, cpha_d;
  logic          lsb_q, lsb_d;
  logic [NW-1:0] n_q, n_d;
  logic [W-1:0]  tx_q, tx_d;
  logic [W-1:0]  rx_q, rx_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          phase_q, phase_d;
  logic          fin_q, fin_d;
  logic          sck_q, sck_d;
  logic          sdo_q, sdo_d;
  logic          ss_q, ss_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;

  logic          tick, tick_load, tick_en, edge_go, last;
  logic [LW-1:0] len_c;
  logic [7:0]    div_c, half_new;
  logic [BW-1:0] top_idx, top_idx_new;
  logic [W-1:0]  mask_new, tx_next, rx_sample;

  // Bit that is on the wire next for the given bit order
  function automatic logic cur_bit(input logic [W-1:0] v, input logic lsb,
                                   input logic [BW-1:0] ti);
    return lsb ? v[0] : v[ti];
  endfunction

  // Advance the transmit register by one bit in the given order
  function automatic logic [W-1:0] shift_tx(input logic [W-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  spi_half_tick u_tick (
    .clk  (clk),
    .rst  (rst),
    .load (tick_load),
    .en   (tick_en),
    .half (half_new),
    .tick (tick)
  );

  assign rddata = rx_q;
  assign done   = done_q;
  assign ready  = ready_q;
  assign sck    = sck_q;
  assign sdo    = sdo_q;
  assign ss     = ss_q;

  // Frame parameters derived from the live inputs, used only at start
  always_comb begin
    len_c       = (len > LW'(MAX_BYTES - 1)) ? LW'(MAX_BYTES - 1) : len;
    n_d         = NW'({len_c, 3'b000}) + NW'(8);
    top_idx_new = BW'(n_d - NW'(1));
    mask_new    = (W'(1) << n_d) - W'(1);
    div_c       = (clk_div < CLK_DIV_MIN) ? CLK_DIV_MIN : clk_div;
    half_new    = div_c >> 1;
  end

  // Next-state logic: sequencing, SCK edges, shifting and sampling
  always_comb begin
    state_d   = state_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    bit_cnt_d = bit_cnt_q;
    phase_d   = phase_q;
    fin_d     = fin_q;
    sck_d     = sck_q;
    sdo_d     = sdo_q;
    ss_d      = ss_q;
    done_d    = 1'b0;
    ready_d   = ready_q;
    tick_load = 1'b0;
    edge_go   = 1'b0;
    tick_en   = (state_q != ST_IDLE);
    top_idx   = BW'(n_q - NW'(1));
    last      = (bit_cnt_q == top_idx);
    tx_next   = shift_tx(tx_q, lsb_q);
    rx_sample = lsb_q ? ((rx_q >> 1) | (W'(sdi) << top_idx))
                      : {rx_q[W-2:0], sdi};

    case (state_q)
      ST_IDLE: begin
        cpol_d  = cpol;
        sck_d   = cpol;
        ss_d    = 1'b1;
        sdo_d   = 1'b0;
        ready_d = 1'b1;
        if (start) begin
          cpha_d    = cpha;
          lsb_d     = lsb_first;
          tx_d      = wrdata & mask_new;
          rx_d      = '0;
          bit_cnt_d = '0;
          phase_d   = 1'b0;
          fin_d     = 1'b0;
          ss_d      = 1'b0;
          ready_d   = 1'b0;
          tick_load = 1'b1;
          sdo_d     = cpha ? 1'b0 : cur_bit(wrdata, lsb_first, top_idx_new);
          state_d   = ST_LEAD;
        end
      end
      ST_LEAD: begin
        if (tick) begin
          edge_go = 1'b1;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (tick) begin
          if (fin_q) state_d = ST_TRAIL;
          else       edge_go = 1'b1;
        end
      end
      ST_TRAIL: begin
        if (tick) begin
          state_d = ST_IDLE;
          ss_d    = 1'b1;
          done_d  = 1'b1;
          ready_d = 1'b1;
          sdo_d   = 1'b0;
          sck_d   = cpol_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (edge_go) begin
      sck_d = ~sck_q;
      if (!phase_q) begin
        phase_d = 1'b1;
        if (!cpha_q) begin
          rx_d = rx_sample;
        end else begin
          sdo_d = cur_bit(tx_q, lsb_q, top_idx);
          tx_d  = tx_next;
        end
      end else begin
        phase_d = 1'b0;
        if (cpha_q) begin
          rx_d = rx_sample;
        end else if (!last) begin
          tx_d  = tx_next;
          sdo_d = cur_bit(tx_next, lsb_q, top_idx);
        end
        if (last) fin_d = 1'b1;
        else      bit_cnt_d = bit_cnt_q + BW'(1);
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      n_q       <= NW'(8);
      tx_q      <= '0;
      rx_q      <= '0;
      bit_cnt_q <= '0;
      phase_q   <= 1'b0;
      fin_q     <= 1'b0;
      sck_q     <= 1'b0;
      sdo_q     <= 1'b0;
      ss_q      <= 1'b1;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      lsb_q     <= lsb_d;
      n_q       <= (state_q == ST_IDLE && start) ? n_d : n_q;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      bit_cnt_q <= bit_cnt_d;
      phase_q   <= phase_d;
      fin_q     <= fin_d;
      sck_q     <= sck_d;
      sdo_q     <= sdo_d;
      ss_q      <= ss_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

endmodule

// File: tb/tb_spi_master_n.sv
// tb/tb_spi_master_n.sv - randomized self-checking bench for spi_master_n with an SPI slave model
module tb_spi_master_n;

  localparam int MB = 4;
  localparam int W  = 8 * MB;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    clk_div;
  logic          cpol, cpha, lsb_first;
  logic [LW-1:0] len;
  logic          start;
  logic [W-1:0]  wrdata;
  logic [W-1:0]  rddata;
  logic          done, ready, sck, sdo, sdi, ss;
  logic          loopback, sdi_slv;

  assign sdi = loopback ? sdo : sdi_slv;

  always #5 clk = ~clk;

  spi_master_n #(.MAX_BYTES(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_div   (clk_div),
    .cpol      (cpol),
    .cpha      (cpha),
    .lsb_first (lsb_first),
    .len       (len),
    .start     (start),
    .wrdata    (wrdata),
    .rddata    (rddata),
    .done      (done),
    .ready     (ready),
    .sck       (sck),
    .sdo       (sdo),
    .sdi       (sdi),
    .ss        (ss)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Slave / observer model state: protocol-level view of one frame
  logic         m_cpol, m_cpha, m_lsb;
  int           m_n;
  logic [W-1:0] m_slv, m_mosi;
  int           kt, kc, n_edges, space_bad;
  time          t0, t_first, t_prev, t_last, m_half_t;
  logic         lead_edge;

  // k-th bit on the wire from the slave word, in the configured order
  function automatic logic slv_bit(input int k);
    if (k >= m_n) return 1'b0;
    return m_lsb ? m_slv[k] : m_slv[m_n-1-k];
  endfunction

  // Slave frame start: with cpha=0 the first bit is presented at ss fall
  always @(negedge ss) begin
    if (rst !== 1'b1) begin
      kt = 0;
      kc = 0;
      if (!m_cpha) sdi_slv = slv_bit(0);
    end
  end

  // Slave edge handling: capture MOSI on sample edges, shift MISO on the others
  always @(sck) begin
    if (rst !== 1'b1 && ss === 1'b0) begin
      n_edges++;
      if (n_edges == 1) t_first = $time;
      else if ($time - t_prev != m_half_t) space_bad++;
      t_prev = $time;
      t_last = $time;
      lead_edge = (sck !== m_cpol);
      if (lead_edge == !m_cpha) begin
        if (kc < m_n) begin
          if (m_lsb) m_mosi[kc] = sdo;
          else       m_mosi[m_n-1-kc] = sdo;
        end
        kc++;
      end else if (m_cpha) begin
        sdi_slv = slv_bit(kt);
        kt++;
      end else begin
        kt++;
        sdi_slv = slv_bit(kt);
      end
    end
  end

  task automatic setup(input logic c_pol, input logic c_pha, input logic c_lsb,
                       input logic [LW-1:0] c_len, input logic [7:0] c_div,
                       input logic [W-1:0] c_wr, input logic [W-1:0] c_slv,
                       input logic c_loop);
    @(negedge clk);
    cpol = c_pol; cpha = c_pha; lsb_first = c_lsb; len = c_len;
    clk_div = c_div; wrdata = c_wr; loopback = c_loop;
    m_cpol = c_pol; m_cpha = c_pha; m_lsb = c_lsb; m_slv = c_slv;
    m_n = 8 * (int'(c_len) + 1);
    m_half_t = ((c_div < 8'd4) ? 4 : int'(c_div)) / 2 * 10;
    m_mosi = '0; n_edges = 0; space_bad = 0; sdi_slv = 1'b0;
  endtask

  task automatic run_frame(input string nm, input logic c_pol, input logic c_pha,
                           input logic c_lsb, input logic [LW-1:0] c_len,
                           input logic [7:0] c_div, input logic [W-1:0] c_wr,
                           input logic [W-1:0] c_slv, input logic c_loop,
                           input logic noise);
    int h, n, lat, cyc;
    logic [W-1:0] mask, exp_rd;
    logic ss1, rdy1, got_done;
    setup(c_pol, c_pha, c_lsb, c_len, c_div, c_wr, c_slv, c_loop);
    n    = m_n;
    h    = ((c_div < 8'd4) ? 4 : int'(c_div)) / 2;
    lat  = 1 + (2 * n + 2) * h;
    mask = (n >= W) ? '1 : ((W'(1) << n) - W'(1));
    exp_rd = (c_loop ? c_wr : c_slv) & mask;
    @(negedge clk);
    chk({nm, "_idle_sck"}, 64'(sck), 64'(c_pol));
    chk({nm, "_idle_rdy"}, 64'(ready), 64'd1);
    start = 1'b1;
    @(posedge clk);
    t0 = $time;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    ss1 = ss;
    rdy1 = ready;
    got_done = done;
    while (!got_done && cyc < lat + 40) begin
      @(negedge clk);
      cyc++;
      if (noise) begin
        if (cyc == 2 || cyc == h + 5) start = 1'b1;
        else start = 1'b0;
      end
      got_done = done;
    end
    start = 1'b0;
    chk({nm, "_ss_lead"}, 64'(ss1), 64'd0);
    chk({nm, "_ready_drop"}, 64'(rdy1), 64'd0);
    chk({nm, "_done_seen"}, 64'(got_done), 64'd1);
    chk({nm, "_done_lat"}, 64'(cyc), 64'(lat));
    chk({nm, "_rddata"}, 64'(rddata), 64'(exp_rd));
    chk({nm, "_mosi"}, 64'(m_mosi), 64'(c_wr & mask));
    chk({nm, "_edges"}, 64'(n_edges), 64'(2 * n));
    chk({nm, "_first_edge"}, 64'(t_first - t0), 64'(h * 10));
    chk({nm, "_last_edge"}, 64'(t_last - t0), 64'(2 * n * h * 10));
    chk({nm, "_spacing"}, 64'(space_bad), 64'd0);
    chk({nm, "_ss_end"}, 64'(ss), 64'd1);
    chk({nm, "_sck_end"}, 64'(sck), 64'(c_pol));
    chk({nm, "_ready_end"}, 64'(ready), 64'd1);
    @(negedge clk);
    chk({nm, "_done_pulse"}, 64'(done), 64'd0);
    chk({nm, "_rd_hold"}, 64'(rddata), 64'(exp_rd));
    if (noise) begin
      repeat (8) @(negedge clk);
      chk({nm, "_no_retrig_ss"}, 64'(ss), 64'd1);
      chk({nm, "_no_retrig_rdy"}, 64'(ready), 64'd1);
    end
  endtask

  initial begin
    int dc, gap;
    bit second;
    rst = 1'b1; start = 1'b0; clk_div = 8'd4; cpol = 1'b0; cpha = 1'b0;
    lsb_first = 1'b0; len = '0; wrdata = '0; loopback = 1'b1; sdi_slv = 1'b0;
    m_cpol = 1'b0; m_cpha = 1'b0; m_lsb = 1'b0; m_n = 8; m_slv = '0; m_mosi = '0;
    kt = 0; kc = 0; n_edges = 0; space_bad = 0; m_half_t = 20;
    t0 = 0; t_first = 0; t_prev = 0; t_last = 0;
    repeat (3) @(negedge clk);
    chk("rst_rddata", 64'(rddata), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_sck", 64'(sck), 64'd0);
    chk("rst_sdo", 64'(sdo), 64'd0);
    chk("rst_ss", 64'(ss), 64'd1);
    rst = 1'b0;

    run_frame("m0_a5", 1'b0, 1'b0, 1'b0, 2'd0, 8'd4, 32'h0000_00A5, 32'h0, 1'b1, 1'b0);
    run_frame("m3_lsb", 1'b1, 1'b1, 1'b1, 2'd3, 8'd4, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 1'b0);
    run_frame("m1", 1'b0, 1'b1, 1'b0, 2'd1, 8'd4, 32'h0000_C3F0, 32'h0, 1'b1, 1'b0);
    run_frame("m2", 1'b1, 1'b0, 1'b0, 2'd1, 8'd4, 32'h0000_C3F0, 32'h0, 1'b1, 1'b0);
    run_frame("div2", 1'b0, 1'b0, 1'b1, 2'd0, 8'd2, 32'hFFFF_FF3C, 32'h0000_0096, 1'b0, 1'b0);
    run_frame("div9", 1'b1, 1'b1, 1'b0, 2'd1, 8'd9, 32'h0000_5AC3, 32'h0000_E71B, 1'b0, 1'b0);
    run_frame("noise", 1'b0, 1'b1, 1'b0, 2'd1, 8'd4, 32'h0000_9D2E, 32'h0000_47B1, 1'b0, 1'b1);

    for (int i = 0; i < 12; i++) begin
      run_frame($sformatf("rnd%0d", i), 1'($urandom), 1'($urandom), 1'($urandom),
                LW'($urandom_range(0, 3)), 8'($urandom_range(0, 11)),
                32'($urandom), 32'($urandom), 1'($urandom), 1'b0);
    end

    // start held high: two frames separated by one idle cycle
    setup(1'b0, 1'b0, 1'b0, 2'd0, 8'd4, 32'h0000_005A, 32'h0, 1'b1);
    @(negedge clk);
    start = 1'b1;
    dc = 0; gap = 0; second = 1'b0;
    for (int i = 0; i < 200 && dc < 2; i++) begin
      @(negedge clk);
      if (done) dc++;
      if (dc == 1 && !second) begin
        if (ss) gap++;
        else begin
          second = 1'b1;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("held_done_cnt", 64'(dc), 64'd2);
    chk("held_gap", 64'(gap), 64'd1);
    chk("held_rddata", 64'(rddata), 64'h5A);

    // reset in the middle of a transfer
    setup(1'b1, 1'b0, 1'b0, 2'd1, 8'd4, 32'h0000_FFFF, 32'h0, 1'b1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("mid_rd_nonzero", 64'(rddata != '0), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ss", 64'(ss), 64'd1);
    chk("mid_rst_sck", 64'(sck), 64'd0);
    chk("mid_rst_rddata", 64'(rddata), 64'd0);
    chk("mid_rst_ready", 64'(ready), 64'd1);
    chk("mid_rst_sdo", 64'(sdo), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) dc++;
    end
    chk("mid_rst_no_done", 64'(dc), 64'd0);
    run_frame("post_rst", 1'b1, 1'b0, 1'b0, 2'd1, 8'd4, 32'h0000_3C69, 32'h0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
